// File: rtl/even_parity_checker_rx.sv
// Serial even-parity frame receiver.
// A frame is a start strobe, then WIDTH data bits sent LSB first, then one
// parity bit. Only cycles with sin_valid=1 deliver a bit. A completed frame
// updates data_out/parity_err, pulses done for one cycle, and bumps the
// saturating err_cnt when the parity check fails.
module even_parity_checker_rx #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             done,
  output logic             parity_err,
  output logic             busy,
  output logic [7:0]       err_cnt
);

  // The counter holds 0..WIDTH. It reaches WIDTH only after the last data
  // bit, and by then the state has already moved to PARITY.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  state_t           state;
  state_t           next_state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic             run_par;
  logic             clear;
  logic             shift_en;
  logic             complete;
  logic             frame_err;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and datapath controls. In every state, start takes priority
  // and restarts the frame, so a parity bit that arrives together with start
  // is discarded.
  always_comb begin
    next_state = state;
    clear      = 1'b0;
    shift_en   = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clear      = 1'b1;
          next_state = DATA;
        end
      end
      DATA: begin
        if (start) begin
          clear      = 1'b1;
          next_state = DATA;
        end else if (sin_valid) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            next_state = PARITY;
          end
        end
      end
      PARITY: begin
        if (start) begin
          clear      = 1'b1;
          next_state = DATA;
        end else if (sin_valid) begin
          complete   = 1'b1;
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign frame_err = run_par ^ sin;

  // Shift register, bit counter and running parity. Bits enter at the MSB
  // and move right, so the first bit received ends up in bit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt   <= '0;
      run_par   <= 1'b0;
      shift_reg <= '0;
    end else if (clear) begin
      bit_cnt <= '0;
      run_par <= 1'b0;
    end else if (shift_en) begin
      bit_cnt   <= bit_cnt + CW'(1);
      run_par   <= run_par ^ sin;
      shift_reg <= {sin, shift_reg[WIDTH-1:1]};
    end
  end

  // Registered frame results. They are loaded on the parity-bit edge and
  // hold until the next completed frame. err_cnt stops at 255.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out   <= '0;
      parity_err <= 1'b0;
      done       <= 1'b0;
      err_cnt    <= 8'd0;
    end else begin
      done <= complete;
      if (complete) begin
        data_out   <= shift_reg;
        parity_err <= frame_err;
        if (frame_err && (err_cnt != 8'hFF)) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_even_parity_checker_rx.sv
// Self-checking bench for even_parity_checker_rx with randomized gaps and data.
module tb_even_parity_checker_rx;

  logic        clk;
  logic        reset;
  logic        start;
  logic        sin;
  logic        sin_valid;
  logic [31:0] data_out;
  logic        done;
  logic        parity_err;
  logic        busy;
  logic [7:0]  err_cnt;

  int checks;
  int errors;

  // Reference model state: the results of the most recent completed frame
  logic [31:0] exp_data;
  logic        exp_perr;
  int          exp_cnt;

  even_parity_checker_rx #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .data_out   (data_out),
    .done       (done),
    .parity_err (parity_err),
    .busy       (busy),
    .err_cnt    (err_cnt)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output with the model while no completion is expected.
  task automatic check_held(input string tag, input logic exp_busy);
    check_output({tag, " done"}, {31'd0, done}, 32'd0);
    check_output({tag, " busy"}, {31'd0, busy}, {31'd0, exp_busy});
    check_output({tag, " data_out"}, data_out, exp_data);
    check_output({tag, " parity_err"}, {31'd0, parity_err}, {31'd0, exp_perr});
    check_output({tag, " err_cnt"}, {24'd0, err_cnt}, exp_cnt[31:0]);
  endtask

  // Start strobe with random garbage on sin/sin_valid, which must be ignored.
  task automatic do_start();
    start     = 1'b1;
    sin       = 1'($urandom);
    sin_valid = 1'($urandom);
    tick();
    start     = 1'b0;
    sin_valid = 1'b0;
    check_output("start done", {31'd0, done}, 32'd0);
    check_output("start busy", {31'd0, busy}, 32'd1);
  endtask

  // Optional idle gap, then one valid bit. busy must stay high throughout.
  task automatic send_bit(input logic b, input int max_gap, input logic is_last);
    int gap;
    gap = (max_gap > 0 && ($urandom % 2) == 1) ? int'($urandom_range(max_gap, 1)) : 0;
    for (int g = 0; g < gap; g++) begin
      sin       = 1'($urandom);
      sin_valid = 1'b0;
      tick();
      check_output("gap busy", {31'd0, busy}, 32'd1);
      check_output("gap done", {31'd0, done}, 32'd0);
    end
    sin       = b;
    sin_valid = 1'b1;
    tick();
    sin_valid = 1'b0;
    if (!is_last) begin
      check_output("bit busy", {31'd0, busy}, 32'd1);
      check_output("bit done", {31'd0, done}, 32'd0);
    end
  endtask

  // Full frame, followed by checks of the completion cycle against the model.
  task automatic send_frame(input logic [31:0] word, input logic pbit, input int max_gap);
    do_start();
    for (int i = 0; i < 32; i++) begin
      send_bit(word[i], max_gap, 1'b0);
    end
    send_bit(pbit, max_gap, 1'b1);
    exp_data = word;
    exp_perr = 1'((($countones(word)) + int'(pbit)) % 2);
    if (exp_perr && exp_cnt < 255) exp_cnt++;
    check_output("frame done", {31'd0, done}, 32'd1);
    check_output("frame busy", {31'd0, busy}, 32'd0);
    check_output("frame data_out", data_out, exp_data);
    check_output("frame parity_err", {31'd0, parity_err}, {31'd0, exp_perr});
    check_output("frame err_cnt", {24'd0, err_cnt}, exp_cnt[31:0]);
  endtask

  initial begin
    logic [31:0] w;
    checks    = 0;
    errors    = 0;
    exp_data  = 32'd0;
    exp_perr  = 1'b0;
    exp_cnt   = 0;
    reset     = 1'b1;
    start     = 1'b0;
    sin       = 1'b0;
    sin_valid = 1'b0;
    tick();
    tick();
    check_held("reset", 1'b0);
    reset = 1'b0;
    tick();

    // Valid bits without a start strobe must not begin a frame
    for (int i = 0; i < 5; i++) begin
      sin       = 1'($urandom);
      sin_valid = 1'b1;
      tick();
      check_held("no start", 1'b0);
    end
    sin_valid = 1'b0;

    // Good and bad parity on the same word
    send_frame(32'hABC1FF06, 1'b0, 0);
    tick();
    check_held("after good frame", 1'b0);
    send_frame(32'hABC1FF06, 1'b1, 0);
    tick();
    check_held("after bad frame", 1'b0);

    // Gapped frame
    send_frame(32'h00000001, 1'b1, 5);
    tick();

    // Abort after 10 bits, then a complete frame
    do_start();
    for (int i = 0; i < 10; i++) send_bit(1'($urandom), 0, 1'b0);
    send_frame(32'hFFFFFFFF, 1'b0, 0);
    tick();
    check_held("after abort frame", 1'b0);

    // Start together with the parity bit aborts the frame
    do_start();
    for (int i = 0; i < 32; i++) send_bit(1'($urandom), 0, 1'b0);
    start     = 1'b1;
    sin       = 1'b1;
    sin_valid = 1'b1;
    tick();
    start     = 1'b0;
    sin_valid = 1'b0;
    check_held("parity abort", 1'b1);
    tick();
    check_held("parity abort hold", 1'b1);

    // Random frames with random gaps
    for (int f = 0; f < 6; f++) begin
      w = $urandom;
      send_frame(w, 1'($urandom), 3);
    end
    tick();

    // Reset mid-frame clears everything at once
    do_start();
    for (int i = 0; i < 20; i++) send_bit(1'($urandom), 0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    exp_data = 32'd0;
    exp_perr = 1'b0;
    exp_cnt  = 0;
    check_held("async reset", 1'b0);
    tick();
    reset = 1'b0;
    tick();
    check_held("post reset", 1'b0);
    send_frame(32'h12345678, 1'b1, 0);

    // Back-to-back bad-parity frames saturate err_cnt
    for (int f = 0; f < 260; f++) begin
      w = $urandom;
      send_frame(w, ~(^w), 0);
    end
    check_output("sat err_cnt", {24'd0, err_cnt}, 32'd255);
    tick();
    check_held("sat hold", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
